// File: rtl/fp_mant_normalizer.sv
// Multi-cycle left-shift normalizer for single-precision significands.
// Shifts by 4 or 1 per clock until the hidden bit is set, the value is zero, or the exponent bottoms out.
module fp_mant_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] mant_in,
  input  logic [7:0]  exp_in,
  output logic        busy,
  output logic        done,
  output logic [22:0] mant_out,
  output logic [7:0]  exp_out,
  output logic [4:0]  shamt_out,
  output logic        zero,
  output logic        denorm
);

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse,
  // and busy covers every cycle from the accepting edge to the done edge.
  typedef enum logic {IDLE = 1'b0, NORM = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [23:0] m, m_nxt;
  logic [7:0]  e, e_nxt;
  logic [4:0]  s, s_nxt;
  logic        term;
  logic [22:0] mant_res;
  logic [7:0]  exp_res;
  logic        zero_res;
  logic        denorm_res;

  always_comb begin
    state_nxt  = state;
    m_nxt      = m;
    e_nxt      = e;
    s_nxt      = s;
    term       = 1'b0;
    mant_res   = m[22:0];
    exp_res    = e;
    zero_res   = 1'b0;
    denorm_res = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = NORM;
          m_nxt     = mant_in;
          e_nxt     = (exp_in == 8'd0) ? 8'd1 : exp_in;
          s_nxt     = 5'd0;
        end
      end
      NORM: begin
        if (m == 24'd0) begin
          term     = 1'b1;
          mant_res = 23'd0;
          exp_res  = 8'd0;
          zero_res = 1'b1;
        end else if (m[23]) begin
          term = 1'b1;
        end else if (e == 8'd1) begin
          term       = 1'b1;
          exp_res    = 8'd0;
          denorm_res = 1'b1;
        end else if (m[23:20] == 4'd0 && e >= 8'd5) begin
          // e >= 5 keeps the working exponent at 1 or above after the wide step
          m_nxt = {m[19:0], 4'b0000};
          e_nxt = e - 8'd4;
          s_nxt = s + 5'd4;
        end else begin
          m_nxt = {m[22:0], 1'b0};
          e_nxt = e - 8'd1;
          s_nxt = s + 5'd1;
        end
        if (term) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m         <= 24'd0;
      e         <= 8'd0;
      s         <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mant_out  <= 23'd0;
      exp_out   <= 8'd0;
      shamt_out <= 5'd0;
      zero      <= 1'b0;
      denorm    <= 1'b0;
    end else begin
      m    <= m_nxt;
      e    <= e_nxt;
      s    <= s_nxt;
      busy <= (state_nxt == NORM);
      done <= term;
      if (term) begin
        mant_out  <= mant_res;
        exp_out   <= exp_res;
        shamt_out <= s;
        zero      <= zero_res;
        denorm    <= denorm_res;
      end
    end
  end

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Bench for fp_mant_normalizer: directed and random operations checked against
// a leading-zero-count reference model, plus handshake and mid-operation reset.
module tb_fp_mant_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [23:0] mant_in = 24'd0;
  logic [7:0]  exp_in = 8'd0;
  logic        busy, done, zero, denorm;
  logic [22:0] mant_out;
  logic [7:0]  exp_out;
  logic [4:0]  shamt_out;

  int n_tests = 0;
  int n_fail  = 0;

  // result word = {mant_out, exp_out, shamt_out, zero, denorm}
  logic [37:0] exp_q[$];
  logic [37:0] last_res;

  fp_mant_normalizer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mant_in(mant_in), .exp_in(exp_in),
    .busy(busy), .done(done), .mant_out(mant_out), .exp_out(exp_out),
    .shamt_out(shamt_out), .zero(zero), .denorm(denorm)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] result_word();
    return {mant_out, exp_out, shamt_out, zero, denorm};
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: shift by the leading-zero count, limited so the exponent stops at 1.
  function automatic void model(input logic [23:0] m, input logic [7:0] ex,
                                output logic [37:0] res, output int steps);
    int          e0;
    int          lz;
    int          sh;
    logic [7:0]  ex_o;
    logic [4:0]  sh5;
    logic [23:0] mm;
    logic        dn;
    e0 = (ex == 8'd0) ? 1 : int'(ex);
    if (m == 24'd0) begin
      res   = {23'd0, 8'd0, 5'd0, 1'b1, 1'b0};
      steps = 0;
    end else begin
      lz = 0;
      while (!m[23 - lz]) lz++;
      if (lz <= e0 - 1) begin
        sh = lz; ex_o = 8'(e0 - lz); dn = 1'b0;
      end else begin
        sh = e0 - 1; ex_o = 8'd0; dn = 1'b1;
      end
      mm    = m << sh;
      sh5   = 5'(sh);
      res   = {mm[22:0], ex_o, sh5, 1'b0, dn};
      steps = sh / 4 + sh % 4;
    end
  endfunction

  // Runs one operation. pulse_mask bit k drives start before edge k (k >= 1).
  // With check_hold set, outputs must keep hold_val until done.
  task automatic run_op(input logic [23:0] m, input logic [7:0] ex, input int pulse_mask,
                        input bit check_hold, input logic [37:0] hold_val);
    logic [37:0] res;
    logic [37:0] expr;
    int          steps;
    int          k;
    bit          got;
    model(m, ex, res, steps);
    exp_q.push_back(res);
    @(negedge clk);
    start = 1'b1; mant_in = m; exp_in = ex;
    @(negedge clk);
    start = 1'b0; mant_in = 24'($urandom); exp_in = 8'($urandom);
    check("busy_after_accept", 40'(busy), 40'd1);
    k = 1; got = 1'b0;
    while (k <= 40 && !got) begin
      start = pulse_mask[k];
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = 1'b1;
      end else begin
        check("busy_during_op", 40'(busy), 40'd1);
        if (check_hold) check("outputs_hold", 40'(result_word()), 40'(hold_val));
        k++;
      end
    end
    if (!got) begin
      check("done_timeout", 40'(done), 40'd1);
      void'(exp_q.pop_front());
    end else begin
      expr = exp_q.pop_front();
      check("latency_edges", 40'(k), 40'(steps + 1));
      check("busy_at_done", 40'(busy), 40'd0);
      check("result", 40'(result_word()), 40'(expr));
      last_res = expr;
      @(negedge clk);
      check("done_one_cycle", 40'(done), 40'd0);
      check("result_held", 40'(result_word()), 40'(expr));
    end
  endtask

  initial begin
    logic [23:0] rm;
    logic [7:0]  re;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, result_word()}, 40'd0);
    rst_n = 1'b1;

    // normalized input
    run_op(24'h800001, 8'h80, 0, 1'b0, 38'd0);
    check("norm_mant", 40'(mant_out), 40'h000001);
    check("norm_exp", 40'(exp_out), 40'h80);

    // maximum shift: 5 wide + 3 single steps
    run_op(24'h000001, 8'd200, 0, 1'b0, 38'd0);
    check("max_exp", 40'(exp_out), 40'd177);
    check("max_shamt", 40'(shamt_out), 40'd23);
    check("max_mant", 40'(mant_out), 40'd0);

    // underflow stop
    run_op(24'h000100, 8'd3, 0, 1'b0, 38'd0);
    check("uf_mant", 40'(mant_out), 40'h000400);
    check("uf_flags", {38'd0, zero, denorm}, 40'd1);
    check("uf_shamt", 40'(shamt_out), 40'd2);
    run_op(24'h400000, 8'd0, 0, 1'b0, 38'd0);
    check("exp0_denorm", {exp_out, mant_out, denorm}, {8'd0, 23'h400000, 1'b1});

    // zero
    run_op(24'h000000, 8'h7F, 0, 1'b0, 38'd0);
    check("zero_flag", {39'd0, zero}, 40'd1);

    // start pulses on edges 2 and 5 are ignored; exactly one done
    run_op(24'h000001, 8'd200, (1 << 2) | (1 << 5), 1'b0, 38'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_extra_done", 40'(done), 40'd0);
    end
    run_op(24'h012345, 8'd90, 0, 1'b1, last_res);

    // random operations, biased towards small exponents for underflow coverage
    for (int i = 0; i < 40; i++) begin
      rm = 24'($urandom) >> $urandom_range(0, 24);
      re = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      run_op(rm, re, 0, 1'b1, last_res);
    end
    run_op(24'h000333, 8'd100, 0, 1'b0, 38'd0);

    // reset during cycle 4 of a max-shift operation
    @(negedge clk);
    start = 1'b1; mant_in = 24'h000001; exp_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", {busy, done, result_word()}, 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_done_after_reset", {38'd0, done, busy}, 40'd0);
    end
    run_op(24'h800000, 8'h7F, 0, 1'b0, 38'd0);
    check("post_reset_exp", 40'(exp_out), 40'h7F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mant_normalizer.md
# fp_mant_normalizer

Multi-cycle left-shift normalizer for the single-precision FP datapath. It is the counterpart of the mantissa-alignment right shifter.

- It accepts an unnormalized 24-bit significand (hidden-bit position = bit 23) and an 8-bit biased exponent.
- It shifts the significand left until the hidden bit is set, decrementing the exponent for every bit shifted.
- It stops early on zero or exponent underflow, and then returns a denormal.
- It sits after the FP adder's subtract path and feeds the rounding/pack stage.

## Interface

- No parameters. Widths are fixed at IEEE-754 single precision: 24-bit significand, 8-bit exponent.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only while idle.
- mant_in  input  24  unnormalized significand. Bit 23 is the hidden-bit position.
- exp_in  input  8  biased exponent of mant_in. A value of 0 is treated as 1.
- busy  output  1  high from the edge that accepts start until the edge that asserts done.
- done  output  1  one-cycle pulse when the results are valid.
- mant_out  output  23  normalized fraction, hidden bit stripped.
- exp_out  output  8  result biased exponent. 0 for zero or denormal results.
- shamt_out  output  5  total left shift applied (0–23).
- zero  output  1  result is zero. Valid with done, held afterwards.
- denorm  output  1  result is denormal (underflow stop). Valid with done, held afterwards.

## Operation

- Registers: working significand m[23:0], working exponent e[7:0], shift accumulator s[4:0], and the FSM state.
- IDLE
  - When start=1, latch m←mant_in, e←(exp_in==0 ? 1 : exp_in), s←0.
  - Go to NORM and set busy=1.
- NORM: exactly one action per clock, evaluated in this priority order.
  1. m==0: terminate with mant_out=0, exp_out=0, shamt_out=s, zero=1, denorm=0.
  2. m[23]==1: terminate with mant_out=m[22:0], exp_out=e, shamt_out=s, zero=0, denorm=0.
  3. e==1 (and m[23]==0): terminate with mant_out=m[22:0], exp_out=0, shamt_out=s, zero=0, denorm=1.
  4. m[23:20]==0 and e>=5: m←m<<4, e←e−4, s←s+4. Stay in NORM.
  5. Otherwise: m←m<<1, e←e−1, s←s+1. Stay in NORM.
- Terminate means:
  - register every result output;
  - assert done for one cycle;
  - clear busy;
  - return to IDLE.
- Arithmetic rules:
  - e never drops below 1 inside NORM. The guard e>=5 on the 4-bit step guarantees this.
  - s never exceeds 23, so no saturation logic is needed.
- Outputs hold their last registered values until the next termination. done is the only pulsed output.
- start while busy=1 is ignored. It is not queued. The input buses are don't-care while busy.
- start on the same edge that done is asserted is ignored. The block is in NORM on that edge; a new start is accepted from the following edge.
- Reset:
  - asserting rst_n=0 at any time, including mid-NORM, forces IDLE immediately;
  - every output is cleared: busy, done, zero, denorm = 0 and mant_out, exp_out, shamt_out = 0;
  - any operation in flight is discarded and no done is produced for it.

## Timing

- Edge 0 is the edge that samples start in IDLE. N is the number of shift steps (rules 4 and 5) taken.
- Edges 1..N perform the shifts. Edge N+1 terminates, and done is high for the cycle following edge N+1.
- Latency: N+1 edges from accept to done.
  - Already-normalized or zero input: N=0, so done follows edge 1.
  - Worst case, mant_in=0x000001 with a large exponent: N=8 (five 4-bit steps plus three 1-bit steps), so done follows edge 9.
- busy is high for cycles 1..N+1. It falls on the same edge that done rises.
- Throughput: one operation per N+2 cycles at best, because IDLE must be re-entered before the next start is accepted.

## Test plan

- Normalized input: mant_in=0x800001, exp_in=0x80.
  - Response: done after edge 1, mant_out=0x000001, exp_out=0x80, shamt_out=0, zero=0, denorm=0.
- Maximum shift: mant_in=0x000001, exp_in=200.
  - Response: busy for 9 cycles, then done with mant_out=0x000000, exp_out=177, shamt_out=23.
  - Check exactly 5 four-bit steps followed by 3 one-bit steps.
- Underflow: mant_in=0x000100, exp_in=3.
  - Response: two 1-bit shifts, then done after edge 3 with mant_out=0x000400, exp_out=0, shamt_out=2, denorm=1.
  - Also check exp_in=0 with mant_in=0x400000: immediate denorm, exp_out=0, mant_out=0x400000, shamt_out=0.
- Zero: mant_in=0, exp_in=0x7F.
  - Response: done after edge 1, zero=1, exp_out=0, mant_out=0, shamt_out=0.
- Handshake: pulse start again on edges 2 and 5 during the mant_in=0x000001 operation.
  - Response: both pulses ignored, the result is unchanged, and exactly one done pulse is produced.
  - After done, a new start is accepted and the prior outputs hold until its done.
- Reset mid-op: drop rst_n during cycle 4 of a max-shift operation.
  - Response: all outputs go to 0 asynchronously and no done appears.
  - After release, a fresh start with 0x800000/0x7F completes normally after edge 1.
